frac_to_decimal_stream: RTL and testbench
=========================================

// Module: frac_to_decimal_stream
// PURPOSE
//  Parametrised converter: WIDTH-bit binary fraction (value = frac / 2^WIDTH) to a stream
//  of decimal digits, most significant first, one digit per accepted handshake.
//  Each digit is produced by an exact x10 multiply-and-split.
//  Digit output uses valid/ready, so a display or UART sink can apply backpressure.
//  Sits between the binary arithmetic core and the digit display/serial formatter.
// PARAMETERS
//  WIDTH       64  fraction width in bits; >= 4
//  NUM_DIGITS  20  digits emitted per conversion; >= 1
//  IDX_W       $clog2(NUM_DIGITS) (min 1), localparam; width of digit_index
// PORTS
//  clk          in   1        clock; all logic on rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  start        in   1        conversion request; accepted only in IDLE
//  abort        in   1        synchronous cancel; honoured in RUN and DONE
//  frac         in   WIDTH    fraction operand; sampled on the accepted start cycle only
//  busy         out  1        high in RUN and DONE
//  digit_data   out  4        BCD digit, 0..9
//  digit_valid  out  1        digit_data/digit_index/digit_last are valid
//  digit_ready  in   1        sink accepts the digit when digit_valid & digit_ready
//  digit_last   out  1        current digit is the final one of this conversion
//  digit_index  out  IDX_W    0-based position of the current digit after the point
//  done         out  1        one-cycle pulse after the last digit is accepted
// BEHAVIOUR
//  Reset: state=IDLE; acc, digit_data, digit_index=0; digit_valid, digit_last, done, busy=0.
//  Arithmetic, per digit: p = acc*10 (WIDTH+4 bits, no overflow). digit = p[WIDTH+3:WIDTH].
//   acc_next = p[WIDTH-1:0]. Result is truncated, never rounded.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: start=1 -> first digit computed from frac. Next cycle: digit_valid=1, index 0, RUN.
//    Latency from start to first digit_valid is 1 cycle.
//   RUN: outputs stay stable while digit_valid & !digit_ready (no change, no drop).
//    Handshake on a non-last digit: next digit is loaded the same edge, valid stays 1.
//    With ready held high, one digit per cycle.
//    Handshake on digit_last -> digit_valid=0, go to DONE.
//   DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
//  digit_last = (digit_index == NUM_DIGITS-1), plus the early-stop rule in CONFIGURATION.
//  start while busy: ignored; no re-latch of frac, no effect on the stream.
//  abort in RUN/DONE: next edge -> IDLE; digit_valid, done, digit_last=0; no done pulse.
//   abort beats a same-cycle handshake.
//  abort in IDLE: no effect. start and abort together in IDLE: start wins.
//  rst_n low at any time, including mid-stream: immediate return to reset values.
//   Partial stream is discarded.
//  frac=0: emits NUM_DIGITS zeros (or one zero under the early-stop rule).
//  NUM_DIGITS=1: the first digit carries digit_last.
// CONFIGURATION
//  F2D_EARLY_STOP_EN defined: digit_last is also set when acc_next==0 for that digit.
//   Stream ends at the last significant digit. At least one digit is always emitted.
//   digit_index of the final digit may be < NUM_DIGITS-1.
//  Undefined: always exactly NUM_DIGITS digits; early-stop comparator not built.
// TESTING (WIDTH=8, NUM_DIGITS=4 unless noted)
//  1 Reset
//     rst_n low, then high -> all outputs 0, busy=0.
//     start ignored while rst_n low.
//  2 frac=8'h80, ready=1
//     -> digits 5,0,0,0; index 0..3; last on index 3; done 1 cycle later.
//     Early-stop build: single digit 5, last=1.
//  3 Truncation values
//     frac=8'h01 -> 0,0,3,9. frac=8'hFF -> 9,9,6,0.
//     Early-stop build: same, since no remainder reaches 0.
//  4 Backpressure
//     frac=8'h01, ready low 3 cycles on index 2.
//     -> digit_data=3, index=2, valid=1 held stable; resumes with 9, last.
//  5 Mid-stream events
//     start with frac=8'h80 during RUN -> ignored, stream stays 0,0,3,9.
//     abort at index 1 -> IDLE next cycle, no done.
//     rst_n low at index 2 -> immediate reset values.
//  6 Throughput
//     WIDTH=64, NUM_DIGITS=20, frac=64'h8000_0000_0000_0000, ready=1.
//     -> 20 digits in 20 consecutive cycles: 5 then nineteen 0s.

Source files
------------

// File: rtl/frac_to_decimal_stream.sv
// frac_to_decimal_stream
//   Converts a WIDTH-bit binary fraction (value = frac / 2^WIDTH) into a stream
//   of BCD digits, most significant first, one digit per valid/ready handshake.
//   Each digit comes from an exact x10 multiply: the top 4 bits of acc*10 are the
//   digit and the low WIDTH bits are the remainder carried to the next digit.
//   The result is truncated, never rounded.
//
//   Optional feature macro: F2D_EARLY_STOP_EN -- when defined, the stream ends at
//   the first digit whose remainder is zero (at least one digit is always sent).
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         conversion request, accepted only in IDLE
//   abort         synchronous cancel, honoured in RUN and DONE
//   frac          fraction operand, sampled on the accepted start cycle
//   busy          high in RUN and DONE
//   digit_data    current BCD digit
//   digit_valid   digit_data / digit_index / digit_last are valid
//   digit_ready   sink accepts the digit when digit_valid & digit_ready
//   digit_last    current digit is the final one of this conversion
//   digit_index   0-based position of the current digit after the point
//   done          one-cycle pulse after the last digit is accepted
module frac_to_decimal_stream #(
  parameter  int WIDTH      = 64,
  parameter  int NUM_DIGITS = 20,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] frac,
  output logic             busy,
  output logic [3:0]       digit_data,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             digit_last,
  output logic [IDX_W-1:0] digit_index,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]         digit_q, digit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  // One shared x10 datapath: fed by frac when starting, by the remainder otherwise.
  logic [WIDTH-1:0]   mul_src;
  logic [WIDTH+3:0]   prod;
  logic [3:0]         dig;
  logic [WIDTH-1:0]   rem;
  logic [IDX_W-1:0]   idx_inc;
  logic               early;

  assign mul_src = (state_q == IDLE) ? frac : acc_q;
  assign prod    = ({4'b0, mul_src} << 3) + ({4'b0, mul_src} << 1);
  assign dig     = prod[WIDTH+3:WIDTH];
  assign rem     = prod[WIDTH-1:0];
  assign idx_inc = idx_q + IDX_W'(1);

`ifdef F2D_EARLY_STOP_EN
  assign early = (rem == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    digit_d = digit_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // start wins over a same-cycle abort; abort alone does nothing here
        if (start) begin
          state_d = RUN;
          acc_d   = rem;
          digit_d = dig;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (LAST_IDX == '0) | early;
        end
      end
      RUN: begin
        // abort beats a handshake in the same cycle
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (valid_q && digit_ready) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            acc_d   = rem;
            digit_d = dig;
            idx_d   = idx_inc;
            last_d  = (idx_inc == LAST_IDX) | early;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      digit_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      digit_q <= digit_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign digit_data  = digit_q;
  assign digit_valid = valid_q;
  assign digit_last  = last_q;
  assign digit_index = idx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_frac_to_decimal_stream.sv
module tb_frac_to_decimal_stream;

`ifdef F2D_EARLY_STOP_EN
  localparam bit ES = 1'b1;
`else
  localparam bit ES = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort, ready;

  // main DUT: WIDTH=8, NUM_DIGITS=4
  logic       start, busy, valid, last, done;
  logic [7:0] frac;
  logic [3:0] data;
  logic [1:0] idx;

  frac_to_decimal_stream #(.WIDTH(8), .NUM_DIGITS(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frac(frac),
    .busy(busy), .digit_data(data), .digit_valid(valid), .digit_ready(ready),
    .digit_last(last), .digit_index(idx), .done(done));

  // throughput DUT: WIDTH=64, NUM_DIGITS=20
  logic        start64, busy64, valid64, last64, done64;
  logic [63:0] frac64;
  logic [3:0]  data64;
  logic [4:0]  idx64;

  frac_to_decimal_stream #(.WIDTH(64), .NUM_DIGITS(20)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .abort(abort), .frac(frac64),
    .busy(busy64), .digit_data(data64), .digit_valid(valid64), .digit_ready(ready),
    .digit_last(last64), .digit_index(idx64), .done(done64));

  // single-digit DUT: WIDTH=4, NUM_DIGITS=1
  logic       start1, busy1, valid1, last1, done1;
  logic [3:0] frac1, data1;
  logic [0:0] idx1;

  frac_to_decimal_stream #(.WIDTH(4), .NUM_DIGITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .frac(frac1),
    .busy(busy1), .digit_data(data1), .digit_valid(valid1), .digit_ready(ready),
    .digit_last(last1), .digit_index(idx1), .done(done1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // digits packed MSD first: digs[15:12] is index 0
  typedef struct packed {
    logic [7:0]  frac;
    logic [2:0]  n;
    logic [15:0] digs;
  } vec_t;

  vec_t vecs[6];

  // full stream with ready held high, checking every digit and the done pulse
  task automatic run_vec(input logic [7:0] f, input int n, input logic [15:0] digs);
    @(negedge clk); start = 1'b1; frac = f;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("valid", valid, 1);
      chk("data",  data,  digs[15-4*i -: 4]);
      chk("index", idx,   i);
      chk("last",  last,  (i == n-1));
      chk("busy",  busy,  1);
      @(negedge clk);
    end
    chk("valid_off", valid, 0);
    chk("done",      done,  1);
    chk("busy_done", busy,  1);
    @(negedge clk);
    chk("done_clr", done, 0);
    chk("busy_clr", busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'h80, ES ? 3'd1 : 3'd4, 16'h5000};
    vecs[1] = '{8'h01, 3'd4,             16'h0039};
    vecs[2] = '{8'hFF, 3'd4,             16'h9960};
    vecs[3] = '{8'h40, ES ? 3'd2 : 3'd4, 16'h2500};
    vecs[4] = '{8'hC0, ES ? 3'd2 : 3'd4, 16'h7500};
    vecs[5] = '{8'h00, ES ? 3'd1 : 3'd4, 16'h0000};

    rst_n = 1'b0; abort = 1'b0; ready = 1'b1;
    start = 1'b0; frac = '0; start64 = 1'b0; frac64 = '0; start1 = 1'b0; frac1 = '0;

    // reset: start pulses while in reset must be ignored
    repeat (2) @(negedge clk);
    start = 1'b1; frac = 8'h80;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy",  busy,  0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid2", valid, 0);
    chk("rst_busy2",  busy,  0);
    chk("rst_data",   data,  0);
    chk("rst_index",  idx,   0);
    chk("rst_last",   last,  0);
    chk("rst_done",   done,  0);

    // table-driven streams
    for (int v = 0; v < 6; v++) run_vec(vecs[v].frac, int'(vecs[v].n), vecs[v].digs);

    // backpressure: hold index 2 for three cycles
    @(negedge clk); start = 1'b1; frac = 8'h01;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idx2", idx, 2);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", valid, 1);
      chk("bp_data",  data,  3);
      chk("bp_index", idx,   2);
      chk("bp_last",  last,  0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_data3", data, 9);
    chk("bp_idx3",  idx,  3);
    chk("bp_last3", last, 1);
    @(negedge clk);
    chk("bp_done", done, 1);
    @(negedge clk);

    // start during RUN is ignored
    @(negedge clk); start = 1'b1; frac = 8'h01;
    @(negedge clk); start = 1'b0;
    chk("ign_d0", data, 0);
    @(negedge clk);
    start = 1'b1; frac = 8'h80;
    @(negedge clk);
    start = 1'b0;
    chk("ign_d2", data, 3);
    chk("ign_i2", idx,  2);
    @(negedge clk);
    chk("ign_d3", data, 9);
    chk("ign_l3", last, 1);
    @(negedge clk);
    chk("ign_done", done, 1);
    @(negedge clk);

    // abort at index 1: back to IDLE, no done pulse
    @(negedge clk); start = 1'b1; frac = 8'h01;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("ab_idx1", idx, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", valid, 0);
    chk("ab_busy",  busy,  0);
    chk("ab_last",  last,  0);
    chk("ab_done",  done,  0);
    @(negedge clk);
    chk("ab_done2", done, 0);

    // start and abort together in IDLE: start wins; then abort at index 0
    start = 1'b1; abort = 1'b1; frac = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("sa_valid", valid, 1);
    chk("sa_data",  data,  9);
    @(negedge clk);
    abort = 1'b0;
    chk("sa_abort", valid, 0);
    @(negedge clk);

    // asynchronous reset mid-stream at index 2
    start = 1'b1; frac = 8'h01;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mr_idx2", idx, 2);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", valid, 0);
    chk("mr_busy",  busy,  0);
    chk("mr_data",  data,  0);
    chk("mr_index", idx,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // NUM_DIGITS=1: first digit carries last
    start1 = 1'b1; frac1 = 4'h8;
    @(negedge clk); start1 = 1'b0;
    chk("n1_valid", valid1, 1);
    chk("n1_data",  data1,  5);
    chk("n1_index", idx1,   0);
    chk("n1_last",  last1,  1);
    @(negedge clk);
    chk("n1_done",  done1,  1);
    @(negedge clk);

    // throughput on the 64-bit instance: one digit per cycle
    start64 = 1'b1; frac64 = 64'h8000_0000_0000_0000;
    @(negedge clk); start64 = 1'b0;
    for (int i = 0; i < (ES ? 1 : 20); i++) begin
      chk("tp_valid", valid64, 1);
      chk("tp_data",  data64,  (i == 0) ? 5 : 0);
      chk("tp_index", idx64,   i);
      chk("tp_last",  last64,  (i == (ES ? 0 : 19)));
      @(negedge clk);
    end
    chk("tp_done",  done64,  1);
    chk("tp_valid0", valid64, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
